mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Main control sequencer for the multicycle CPU. It decodes the instruction opcode and steps the shared datapath (PC, unified memory, instruction register, memory data register, register file, ALU) through fetch, decode, execute, memory and write-back states. It drives every datapath mux select and write enable. Memory accesses stall on a `mem_ready` handshake, so the memory data register, which loads every clock, always captures valid read data one cycle before write-back.

## Interface
- No parameters. Opcode encodings are fixed: R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, J 6'b000010, ADDI 6'b001000.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (BEQ)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state encoding, for debug
- illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12–15 are unreachable and return to FETCH.
- **FETCH:** assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Assert ir_write and pc_write only in a cycle where mem_ready=1; then go to DECODE.
  - Otherwise hold FETCH.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=00 to precompute the branch target. Next state by opcode:
  - LW or SW → MEM_ADDR
  - R-type → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EX
  - Any other opcode: pulse illegal_op and go to FETCH. The PC is already advanced, so the instruction is skipped.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD for LW, MEM_WR for SW.
- **MEM_RD:** mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
- **MEM_WB:** reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- **MEM_WR:** mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- **EXEC:** alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB.
- **R_WB:** reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
- **JUMP:** pc_write=1, pc_source=10; then FETCH.
- **ADDI_EX:** alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB.
- **ADDI_WB:** reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- Any output not listed for a state is 0.
- mem_read and mem_write are never asserted in the same cycle.
- Write enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write) are asserted only in the states listed above.

## Timing
- Outputs are combinational from state_o, plus mem_ready in FETCH only.
- Reset:
  - A rising edge with rst=1 forces state to FETCH.
  - While rst=1, all outputs are forced to 0, including illegal_op; state_o still shows the registered state.
  - rst overrides any stall or any other transition on the same edge.
  - First fetch request: the cycle after rst deasserts.
- Cycles per instruction with zero wait (mem_ready held at 1):
  - BEQ, J: 3
  - R-type, ADDI, SW: 4
  - LW: 5
- Each memory wait cycle adds one cycle in FETCH, MEM_RD or MEM_WR.
- The MDR captures read data at the edge that leaves MEM_RD; MEM_WB consumes it in the next cycle.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- Reset mid-instruction: any partial write-back is abandoned; the only writes committed are those of states already completed.

## Test plan
- **Reset:** rst=1 for 2 cycles from an arbitrary state → all outputs 0. After release: state_o=0, mem_read=1, i_or_d=0.
- **LW, zero wait:** opcode=100011, mem_ready=1 → state_o sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in state 4.
- **SW with 3 wait cycles:** mem_ready=0 for 3 cycles in MEM_WR → mem_write=1 and i_or_d=1 for 4 cycles. Exactly one mem_ready=1 cycle, then FETCH.
- **BEQ:** opcode=000100, zero=1 and then zero=0 → pc_write_cond=1, pc_source=01, alu_op=01 in state 8; 3 cycles in both cases.
- **R-type then ADDI:** sequences 0,1,6,7 and 0,1,10,11.
  - R_WB: reg_dst=1, alu_op=10 in EXEC.
  - ADDI_WB: reg_dst=0, alu_src_b=10 in ADDI_EX.
- **Illegal opcode and fetch stall:** opcode=111111 → illegal_op=1 for one cycle in DECODE, then FETCH with no write enables asserted. Fetch with mem_ready=0 for 2 cycles → ir_write and pc_write stay 0 until the mem_ready=1 cycle.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle CPU main control sequencer
//
// Steps the shared datapath through fetch, decode, execute, memory and
// write-back states. It drives every mux select and write enable for the datapath.
// Outputs are decoded from the registered state. In FETCH they also depend on
// i_mem_ready.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_opcode[5:0]    IR[31:26], valid from DECODE onward
//   i_zero           ALU zero flag (gated into the PC enable by the datapath)
//   i_mem_ready      memory completed the current access this cycle
//   o_pc_write       unconditional PC load
//   o_pc_write_cond  PC load qualified by zero (BEQ)
//   o_i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   o_mem_read       memory read request
//   o_mem_write      memory write request
//   o_ir_write       IR load
//   o_mem_to_reg     register write data: 0 = ALUOut, 1 = MDR
//   o_reg_dst        destination register: 0 = rt, 1 = rd
//   o_reg_write      register file write enable
//   o_alu_src_a      0 = PC, 1 = register A
//   o_alu_src_b[1:0] 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//   o_alu_op[1:0]    00 = add, 01 = subtract, 10 = decode funct
//   o_pc_source[1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   o_state[3:0]     current state encoding (debug)
//   o_illegal_op     one-cycle pulse on an undefined opcode in DECODE

module mc_control_fsm (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic [3:0] o_state,
    output logic       o_illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_illegal_op;

    // The zero flag only matters to the datapath's PC enable
    // (pc_write | pc_write_cond & zero). The sequencer never branches on it.
    logic w_unused_zero;
    assign w_unused_zero = i_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_illegal_op    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Read at PC and compute PC+4. Commit the IR and PC only on the
                // cycle the memory delivers the word.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode decodes.
                w_alu_src_b = 2'b11;
                case (i_opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default: begin
                        // The PC has already advanced, so the bad word is skipped.
                        w_illegal_op = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                // The MDR loads every clock. The edge that leaves this state
                // therefore captures the completed read.
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = i_mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_next      = i_mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_next      = S_FETCH;
            end
            S_ADDI_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: begin
                // Codes 12-15 are unreachable. Recover to FETCH with all outputs idle.
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset silences every output, so a write-back in flight is abandoned
    // on the cycle reset is seen.
    assign o_pc_write      = i_rst ? 1'b0  : w_pc_write;
    assign o_pc_write_cond = i_rst ? 1'b0  : w_pc_write_cond;
    assign o_i_or_d        = i_rst ? 1'b0  : w_i_or_d;
    assign o_mem_read      = i_rst ? 1'b0  : w_mem_read;
    assign o_mem_write     = i_rst ? 1'b0  : w_mem_write;
    assign o_ir_write      = i_rst ? 1'b0  : w_ir_write;
    assign o_mem_to_reg    = i_rst ? 1'b0  : w_mem_to_reg;
    assign o_reg_dst       = i_rst ? 1'b0  : w_reg_dst;
    assign o_reg_write     = i_rst ? 1'b0  : w_reg_write;
    assign o_alu_src_a     = i_rst ? 1'b0  : w_alu_src_a;
    assign o_alu_src_b     = i_rst ? 2'b00 : w_alu_src_b;
    assign o_alu_op        = i_rst ? 2'b00 : w_alu_op;
    assign o_pc_source     = i_rst ? 2'b00 : w_pc_source;
    assign o_illegal_op    = i_rst ? 1'b0  : w_illegal_op;
    assign o_state         = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    int n_vec = 0;
    int n_err = 0;
    logic [20:0] sb_q[$];

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_opcode       (opcode),
        .i_zero         (zero),
        .i_mem_ready    (mem_ready),
        .o_pc_write     (pc_write),
        .o_pc_write_cond(pc_write_cond),
        .o_i_or_d       (i_or_d),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_ir_write     (ir_write),
        .o_mem_to_reg   (mem_to_reg),
        .o_reg_dst      (reg_dst),
        .o_reg_write    (reg_write),
        .o_alu_src_a    (alu_src_a),
        .o_alu_src_b    (alu_src_b),
        .o_alu_op       (alu_op),
        .o_pc_source    (pc_source),
        .o_state        (state_o),
        .o_illegal_op   (illegal_op)
    );

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    // Vector layout: {state, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill}
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic r,
                                            input logic rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, ps;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
            4'd1:  begin asb = 2'b11;
                         ill = !(op inside {RT, LW, SW, BQ, JP, AI}); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            4'd9:  begin pcw = 1; ps = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        if (r) begin
            {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
            asb = 2'b00; aop = 2'b00; ps = 2'b00;
        end
        return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
    endfunction

    task automatic check_vec(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge and push the expected vector.
    // Then pop the expectation and compare it with the DUT outputs 1 ns later.
    task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                       input logic [5:0] op, input logic [3:0] st);
        logic [20:0] got;
        logic [20:0] exp;
        @(negedge clk);
        rst = r; mem_ready = rdy; zero = z; opcode = op;
        sb_q.push_back(exp_vec(st, r, rdy, op));
        #1;
        got = {state_o, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op};
        exp = sb_q.pop_front();
        check_vec(tag, got, exp);
        if (mem_read && mem_write) begin
            n_vec++; n_err++;
            $display("FAIL %s_rw_excl: got read and write together expected exclusive", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc("rst_hold", 1, 1, 0, RT, 4'd0);
        cyc("rst_rel",  0, 0, 0, RT, 4'd0);

        // LW zero wait
        cyc("lw_f",  0, 1, 0, LW, 4'd0);
        cyc("lw_d",  0, 1, 0, LW, 4'd1);
        cyc("lw_ma", 0, 1, 0, LW, 4'd2);
        cyc("lw_rd", 0, 1, 0, LW, 4'd3);
        cyc("lw_wb", 0, 1, 0, LW, 4'd4);

        // SW with 3 wait cycles in MEM_WR
        cyc("sw_f",  0, 1, 0, SW, 4'd0);
        cyc("sw_d",  0, 1, 0, SW, 4'd1);
        cyc("sw_ma", 0, 1, 0, SW, 4'd2);
        for (int i = 0; i < 3; i++) cyc("sw_wait", 0, 0, 0, SW, 4'd5);
        cyc("sw_done", 0, 1, 0, SW, 4'd5);

        // BEQ taken, then not taken
        cyc("beq1_f", 0, 1, 1, BQ, 4'd0);
        cyc("beq1_d", 0, 1, 1, BQ, 4'd1);
        cyc("beq1_b", 0, 1, 1, BQ, 4'd8);
        cyc("beq0_f", 0, 1, 0, BQ, 4'd0);
        cyc("beq0_d", 0, 1, 0, BQ, 4'd1);
        cyc("beq0_b", 0, 1, 0, BQ, 4'd8);

        // R-type then ADDI
        cyc("r_f",  0, 1, 0, RT, 4'd0);
        cyc("r_d",  0, 1, 0, RT, 4'd1);
        cyc("r_ex", 0, 1, 0, RT, 4'd6);
        cyc("r_wb", 0, 1, 0, RT, 4'd7);
        cyc("ai_f",  0, 1, 0, AI, 4'd0);
        cyc("ai_d",  0, 1, 0, AI, 4'd1);
        cyc("ai_ex", 0, 1, 0, AI, 4'd10);
        cyc("ai_wb", 0, 1, 0, AI, 4'd11);

        // Jump
        cyc("j_f", 0, 1, 0, JP, 4'd0);
        cyc("j_d", 0, 1, 0, JP, 4'd1);
        cyc("j_j", 0, 1, 0, JP, 4'd9);

        // Illegal opcode, then a fetch stalled for 2 cycles
        cyc("ill_f", 0, 1, 0, BAD, 4'd0);
        cyc("ill_d", 0, 1, 0, BAD, 4'd1);
        cyc("stall0", 0, 0, 0, RT, 4'd0);
        cyc("stall1", 0, 0, 0, RT, 4'd0);
        cyc("stall_go", 0, 1, 0, RT, 4'd0);
        cyc("stall_d", 0, 1, 0, RT, 4'd1);
        cyc("stall_ex", 0, 1, 0, RT, 4'd6);

        // Reset in R_WB abandons the write-back, then reset during a stalled LW read
        cyc("mid_rst_wb", 1, 1, 0, RT, 4'd7);
        cyc("mid_rst_2",  1, 1, 0, RT, 4'd0);
        cyc("mid_rel",    0, 1, 0, LW, 4'd0);
        cyc("lw2_d",  0, 1, 0, LW, 4'd1);
        cyc("lw2_ma", 0, 0, 0, LW, 4'd2);
        cyc("lw2_rdw", 0, 0, 0, LW, 4'd3);
        cyc("lw2_rst", 1, 1, 0, LW, 4'd3);
        cyc("lw2_rel", 0, 0, 0, LW, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
